psram_opi_phy: RTL and testbench

Octal-DDR PSRAM transfer engine. It sits directly downstream of the PSRAM controller's transfer arbitration (the valid/rdwr/ready/done path fed by the AXI4 slave FSM and the APB config path) and drives the PSRAM pins. It converts one accepted transfer into chip-select setup, a command phase, an address phase, a latency phase, a data phase, chip-select hold, and recovery. One data byte is moved per `clk_i` cycle, with `psram_sck_o` toggling every cycle.

---
 rtl/psram_opi_phy.sv | 239 +++++++++++++++++++++++
 tb/tb_psram_opi_phy.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_opi_phy.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : psram_opi_phy                                                 |
// | Purpose  : Octal-DDR PSRAM transfer engine. Turns one accepted transfer  |
// |            into CE setup, command, address, latency, data, CE hold and   |
// |            recovery phases, moving one data byte per clk_i cycle.        |
// | Ports    : clk_i/rst_n_i (async active-low) ; xfer_* request handshake;  |
// |            cfg_* timing/opcode, addr_i, wr_data_i, wr_mask_i (latched on |
// |            acceptance) ; rd_data_o ; psram_* registered pin interface.   |
// | Options  : PSRAM_DQS_SYNC_EN - read capture follows DQS edges with a     |
// |            16-cycle no-edge timeout; undefined = one byte per DATA cycle.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module psram_opi_phy #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    xfer_valid_i,
  input  logic                    xfer_rdwr_i,
  output logic                    xfer_ready_o,
  output logic                    xfer_done_o,
  input  logic [7:0]              cfg_cmd_i,
  input  logic [7:0]              cfg_lat_i,
  input  logic [1:0]              cfg_tcsp_i,
  input  logic [1:0]              cfg_tchd_i,
  input  logic [7:0]              cfg_recy_i,
  input  logic [31:0]             addr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_mask_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    psram_sck_o,
  output logic                    psram_ce_o,
  output logic                    psram_io_en_o,
  output logic [7:0]              psram_io_out_o,
  input  logic [7:0]              psram_io_in_i,
  output logic                    psram_dqs_en_o,
  output logic                    psram_dqs_out_o,
  input  logic                    psram_dqs_in_i
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(NB + 1);
  localparam logic [IW-1:0] c_idx_one  = IW'(1);
  localparam logic [IW-1:0] c_idx_last = IW'(NB - 1);
  localparam logic [8:0]    c_dqs_tmo  = 9'd15;

  typedef enum logic [2:0] {
    S_IDLE, S_TCSP, S_CMD, S_ADDR, S_WAIT, S_DATA, S_TCHD, S_RECY
  } state_t;

  state_t                  r_state, w_nxt_state;
  logic [8:0]              r_cnt, w_nxt_cnt;
  logic [IW-1:0]           r_idx, w_nxt_idx;
  logic [DATA_WIDTH-1:0]   r_rd_data, w_nxt_rd;

  logic                    r_rdwr;
  logic [7:0]              r_cmd, r_lat, r_recy;
  logic [1:0]              r_tchd;
  logic [31:0]             r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [NB-1:0]           r_mask;

  logic r_sck, r_ce, r_io_en, r_dqs_en, r_dqs_out, r_done;
  logic [7:0] r_io_out;
  logic w_nxt_sck, w_nxt_ce, w_nxt_io_en, w_nxt_dqs_en, w_nxt_dqs_out, w_nxt_done;
  logic [7:0] w_nxt_io_out;

  logic w_accept, w_act_cur, w_act_nxt, w_wr_data_nxt;
  logic w_fixed_rate, w_dqs_edge;

`ifdef PSRAM_DQS_SYNC_EN
  logic r_dqs_q;
  // Reads advance only on a DQS transition; writes keep the fixed byte rate.
  assign w_fixed_rate = ~r_rdwr;
  assign w_dqs_edge   = psram_dqs_in_i ^ r_dqs_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_dqs_q <= 1'b0;
    else          r_dqs_q <= psram_dqs_in_i;
  end
`else
  logic w_unused_dqs;
  assign w_unused_dqs = psram_dqs_in_i;
  assign w_fixed_rate = 1'b1;
  assign w_dqs_edge   = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && xfer_valid_i;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_idx   = r_idx;
    w_nxt_rd    = r_rd_data;
    case (r_state)
      S_IDLE: if (xfer_valid_i) begin
        w_nxt_state = S_TCSP;
        w_nxt_cnt   = {7'd0, cfg_tcsp_i};
      end
      S_TCSP: if (r_cnt == 9'd0) begin
        w_nxt_state = S_CMD;
        w_nxt_cnt   = 9'd1;
      end else w_nxt_cnt = r_cnt - 9'd1;
      S_CMD: if (r_cnt == 9'd0) begin
        w_nxt_state = S_ADDR;
        w_nxt_cnt   = 9'd3;
      end else w_nxt_cnt = r_cnt - 9'd1;
      S_ADDR, S_WAIT: if (r_cnt == 9'd0) begin
        w_nxt_idx = '0;
        // A zero latency skips WAIT entirely.
        if (r_state == S_ADDR && r_lat != 8'd0) begin
          w_nxt_state = S_WAIT;
          w_nxt_cnt   = {r_lat, 1'b0} - 9'd1;
        end else begin
          w_nxt_state = S_DATA;
          w_nxt_cnt   = c_dqs_tmo;
        end
      end else w_nxt_cnt = r_cnt - 9'd1;
      S_DATA: begin
        if (w_fixed_rate || w_dqs_edge) begin
          if (r_rdwr) begin
            for (int b = 0; b < NB; b++)
              if (r_idx == IW'(b)) w_nxt_rd[8*b +: 8] = psram_io_in_i;
          end
          w_nxt_idx = r_idx + c_idx_one;
          w_nxt_cnt = c_dqs_tmo;
          if (r_idx == c_idx_last) begin
            w_nxt_state = S_TCHD;
            w_nxt_cnt   = {7'd0, r_tchd};
          end
        end else if (r_cnt == 9'd0) begin
          // DQS timeout: bytes never strobed in are returned as zero.
          for (int b = 0; b < NB; b++)
            if (IW'(b) >= r_idx) w_nxt_rd[8*b +: 8] = 8'h00;
          w_nxt_state = S_TCHD;
          w_nxt_cnt   = {7'd0, r_tchd};
        end else w_nxt_cnt = r_cnt - 9'd1;
      end
      S_TCHD: if (r_cnt == 9'd0) begin
        w_nxt_state = S_RECY;
        w_nxt_cnt   = {1'b0, r_recy};
      end else w_nxt_cnt = r_cnt - 9'd1;
      S_RECY: if (r_cnt == 9'd0) w_nxt_state = S_IDLE;
              else w_nxt_cnt = r_cnt - 9'd1;
      default: w_nxt_state = S_IDLE;
    endcase

    // Pin values belong to the state being entered, so they are derived from
    // the next state and registered on the same edge.
    w_act_cur     = (r_state == S_CMD) || (r_state == S_ADDR) ||
                    (r_state == S_WAIT) || (r_state == S_DATA);
    w_act_nxt     = (w_nxt_state == S_CMD) || (w_nxt_state == S_ADDR) ||
                    (w_nxt_state == S_WAIT) || (w_nxt_state == S_DATA);
    w_wr_data_nxt = (w_nxt_state == S_DATA) && !r_rdwr;
    w_nxt_sck     = w_act_nxt && (w_act_cur ? ~r_sck : 1'b1);
    w_nxt_ce      = (w_nxt_state == S_IDLE) || (w_nxt_state == S_RECY);
    w_nxt_io_en   = (w_nxt_state == S_CMD) || (w_nxt_state == S_ADDR) || w_wr_data_nxt;
    w_nxt_dqs_en  = w_wr_data_nxt;
    w_nxt_dqs_out = 1'b0;
    w_nxt_io_out  = 8'h00;
    w_nxt_done    = (w_nxt_state == S_RECY) && (w_nxt_cnt == 9'd0);
    if (w_nxt_state == S_CMD) begin
      w_nxt_io_out = r_cmd;
    end else if (w_nxt_state == S_ADDR) begin
      case (w_nxt_cnt[1:0])
        2'd3:    w_nxt_io_out = r_addr[31:24];
        2'd2:    w_nxt_io_out = r_addr[23:16];
        2'd1:    w_nxt_io_out = r_addr[15:8];
        default: w_nxt_io_out = r_addr[7:0];
      endcase
    end else if (w_wr_data_nxt) begin
      for (int b = 0; b < NB; b++) begin
        if (w_nxt_idx == IW'(b)) begin
          w_nxt_io_out  = r_wdata[8*b +: 8];
          w_nxt_dqs_out = ~r_mask[b];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rd_data <= '0;
      r_rdwr    <= 1'b0;
      r_cmd     <= '0;
      r_lat     <= '0;
      r_tchd    <= '0;
      r_recy    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mask    <= '0;
      r_sck     <= 1'b0;
      r_ce      <= 1'b1;
      r_io_en   <= 1'b0;
      r_io_out  <= '0;
      r_dqs_en  <= 1'b0;
      r_dqs_out <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_idx     <= w_nxt_idx;
      r_rd_data <= w_nxt_rd;
      r_sck     <= w_nxt_sck;
      r_ce      <= w_nxt_ce;
      r_io_en   <= w_nxt_io_en;
      r_io_out  <= w_nxt_io_out;
      r_dqs_en  <= w_nxt_dqs_en;
      r_dqs_out <= w_nxt_dqs_out;
      r_done    <= w_nxt_done;
      if (w_accept) begin
        r_rdwr  <= xfer_rdwr_i;
        r_cmd   <= cfg_cmd_i;
        r_lat   <= cfg_lat_i;
        r_tchd  <= cfg_tchd_i;
        r_recy  <= cfg_recy_i;
        r_addr  <= addr_i;
        r_wdata <= wr_data_i;
        r_mask  <= wr_mask_i;
      end
    end
  end

  assign xfer_ready_o    = (r_state == S_IDLE);
  assign xfer_done_o     = r_done;
  assign rd_data_o       = r_rd_data;
  assign psram_sck_o     = r_sck;
  assign psram_ce_o      = r_ce;
  assign psram_io_en_o   = r_io_en;
  assign psram_io_out_o  = r_io_out;
  assign psram_dqs_en_o  = r_dqs_en;
  assign psram_dqs_out_o = r_dqs_out;

endmodule
`default_nettype wire

// File: tb/tb_psram_opi_phy.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_psram_opi_phy                                              |
// | Purpose  : Self-checking bench for psram_opi_phy (default build). Pins   |
// |            are predicted cycle by cycle from the phase lengths of each   |
// |            transfer; a small device model drives DQ/DQS during reads.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_psram_opi_phy;

  localparam int DW = 64;
  localparam int NB = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          xfer_valid_i, xfer_rdwr_i, xfer_ready_o, xfer_done_o;
  logic [7:0]    cfg_cmd_i, cfg_lat_i, cfg_recy_i;
  logic [1:0]    cfg_tcsp_i, cfg_tchd_i;
  logic [31:0]   addr_i;
  logic [DW-1:0] wr_data_i, rd_data_o;
  logic [NB-1:0] wr_mask_i;
  logic          psram_sck_o, psram_ce_o, psram_io_en_o, psram_dqs_en_o, psram_dqs_out_o;
  logic [7:0]    psram_io_out_o, psram_io_in_i;
  logic          psram_dqs_in_i;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_rd   = '0;

  psram_opi_phy #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .xfer_valid_i(xfer_valid_i), .xfer_rdwr_i(xfer_rdwr_i),
    .xfer_ready_o(xfer_ready_o), .xfer_done_o(xfer_done_o),
    .cfg_cmd_i(cfg_cmd_i), .cfg_lat_i(cfg_lat_i), .cfg_tcsp_i(cfg_tcsp_i),
    .cfg_tchd_i(cfg_tchd_i), .cfg_recy_i(cfg_recy_i),
    .addr_i(addr_i), .wr_data_i(wr_data_i), .wr_mask_i(wr_mask_i),
    .rd_data_o(rd_data_o),
    .psram_sck_o(psram_sck_o), .psram_ce_o(psram_ce_o),
    .psram_io_en_o(psram_io_en_o), .psram_io_out_o(psram_io_out_o),
    .psram_io_in_i(psram_io_in_i), .psram_dqs_en_o(psram_dqs_en_o),
    .psram_dqs_out_o(psram_dqs_out_o), .psram_dqs_in_i(psram_dqs_in_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete transfer. Called and returning just after a falling edge.
  // Cycle c counts clk periods after the acceptance edge (c=1 is the first
  // TCSP cycle); every pin is predicted from the phase boundaries.
  task automatic run_xfer(input logic rdwr, input logic [7:0] cmd, input logic [7:0] lat,
                          input logic [1:0] tcsp, input logic [1:0] tchd, input logic [7:0] recy,
                          input logic [31:0] addr, input logic [63:0] wdata, input logic [7:0] mask,
                          input logic [63:0] rpat, input bit keep_valid, input bit immediate,
                          input string tag);
    int s_cmd, s_addr, s_wait, s_data, s_tchd, s_recy, d, waited, i;
    logic in_cmd, in_addr, in_wd, e_ce, e_sck;
    logic [7:0] e_out;
    logic [31:0] a_sh;
    logic [63:0] w_sh;
    logic [12:0] e_pins, g_pins;
    s_cmd  = int'(tcsp) + 2;
    s_addr = s_cmd + 2;
    s_wait = s_addr + 4;
    s_data = s_wait + 2 * int'(lat);
    s_tchd = s_data + NB;
    s_recy = s_tchd + int'(tchd) + 1;
    d      = s_recy + int'(recy);

    xfer_valid_i = 1'b1; xfer_rdwr_i = rdwr; cfg_cmd_i = cmd; cfg_lat_i = lat;
    cfg_tcsp_i = tcsp; cfg_tchd_i = tchd; cfg_recy_i = recy;
    addr_i = addr; wr_data_i = wdata; wr_mask_i = mask;

    waited = 0;
    while (xfer_ready_o !== 1'b1 && waited < 400) begin
      @(negedge clk_i);
      waited++;
    end
    if (immediate) begin
      n_checks++;
      if (waited !== 0) begin
        n_errors++;
        $display("FAIL %s b2b_accept: waited %0d cycles, required 0", tag, waited);
      end
    end
    if (xfer_ready_o !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL %s ready_timeout: ready=%b, required 1", tag, xfer_ready_o);
      return;
    end

    @(posedge clk_i);
    #1;
    // Upstream values move on after acceptance; the transfer must not see it.
    xfer_rdwr_i = 1'($urandom); cfg_cmd_i = 8'($urandom); cfg_lat_i = 8'($urandom);
    cfg_tcsp_i = 2'($urandom); cfg_tchd_i = 2'($urandom); cfg_recy_i = 8'($urandom);
    addr_i = $urandom; wr_data_i = {$urandom, $urandom}; wr_mask_i = 8'($urandom);
    if (!keep_valid) xfer_valid_i = 1'b0;
    if (rdwr) exp_rd = rpat;

    for (int c = 1; c <= d + 1; c++) begin
      @(negedge clk_i);
      if (keep_valid && c == 3) xfer_valid_i = 1'b0;
      if (keep_valid && c == 5) xfer_valid_i = 1'b1;
      // Device model: byte i on DQ with a DQS transition in read DATA cycle i.
      if (rdwr && c >= s_data && c < s_tchd) begin
        w_sh = rpat >> (8 * (c - s_data));
        psram_io_in_i  = w_sh[7:0];
        psram_dqs_in_i = ~psram_dqs_in_i;
      end else begin
        psram_io_in_i = 8'($urandom);
      end

      in_cmd  = (c >= s_cmd)  && (c < s_addr);
      in_addr = (c >= s_addr) && (c < s_wait);
      in_wd   = !rdwr && (c >= s_data) && (c < s_tchd);
      e_ce    = (c >= s_recy);
      e_sck   = (c >= s_cmd) && (c < s_tchd) && (((c - s_cmd) % 2) == 0);
      e_out   = 8'h00;
      if (in_cmd) e_out = cmd;
      if (in_addr) begin
        a_sh  = addr >> (8 * (3 - (c - s_addr)));
        e_out = a_sh[7:0];
      end
      if (in_wd) begin
        w_sh  = wdata >> (8 * (c - s_data));
        e_out = w_sh[7:0];
      end
      i = in_wd ? (c - s_data) : 0;
      e_pins = {e_ce, e_sck, in_cmd | in_addr | in_wd, e_out, in_wd, in_wd & ~mask[i]};
      g_pins = {psram_ce_o, psram_sck_o, psram_io_en_o, psram_io_out_o,
                psram_dqs_en_o, psram_dqs_out_o};
      n_checks++;
      if (g_pins !== e_pins) begin
        n_errors++;
        $display("FAIL %s pins c=%0d: got ce/sck/en/out/dqsen/dm=%h, required %h",
                 tag, c, g_pins, e_pins);
      end
      n_checks++;
      if (xfer_done_o !== (c == d)) begin
        n_errors++;
        $display("FAIL %s done c=%0d: got %b, required %b", tag, c, xfer_done_o, (c == d));
      end
      n_checks++;
      if (xfer_ready_o !== (c == d + 1)) begin
        n_errors++;
        $display("FAIL %s ready c=%0d: got %b, required %b", tag, c, xfer_ready_o, (c == d + 1));
      end
      if (c == d) begin
        n_checks++;
        if (rd_data_o !== exp_rd) begin
          n_errors++;
          $display("FAIL %s rd_data: got %h, required %h", tag, rd_data_o, exp_rd);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; xfer_valid_i = 1'b0; xfer_rdwr_i = 1'b0;
    cfg_cmd_i = '0; cfg_lat_i = '0; cfg_tcsp_i = '0; cfg_tchd_i = '0; cfg_recy_i = '0;
    addr_i = '0; wr_data_i = '0; wr_mask_i = '0; psram_io_in_i = '0; psram_dqs_in_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if ({psram_ce_o, psram_sck_o, psram_io_en_o, psram_io_out_o, psram_dqs_en_o, psram_dqs_out_o}
        !== 13'b1_0_0_00000000_0_0) begin
      n_errors++;
      $display("FAIL reset pins: got ce=%b sck=%b en=%b out=%h dqsen=%b dm=%b, required 1 0 0 00 0 0",
               psram_ce_o, psram_sck_o, psram_io_en_o, psram_io_out_o, psram_dqs_en_o, psram_dqs_out_o);
    end
    n_checks++;
    if (rd_data_o !== 64'h0) begin
      n_errors++;
      $display("FAIL reset rd_data: got %h, required 0", rd_data_o);
    end
    n_checks++;
    if (xfer_done_o !== 1'b0 || xfer_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL reset handshake: got done=%b ready=%b, required 0 1", xfer_done_o, xfer_ready_o);
    end
  endtask

  task automatic test_write();
    run_xfer(1'b0, 8'hA0, 8'd0, 2'd0, 2'd0, 8'd0, 32'h0012_3458,
             64'h8877665544332211, 8'hFF, 64'h0, 1'b0, 1'b0, "write");
  endtask

  task automatic test_masked_write();
    run_xfer(1'b0, 8'hA0, 8'd0, 2'd0, 2'd0, 8'd0, 32'hCAFE_0010,
             64'h0123456789ABCDEF, 8'h0F, 64'h0, 1'b0, 1'b0, "masked_write");
  endtask

  task automatic test_read();
    run_xfer(1'b1, 8'h20, 8'd5, 2'd0, 2'd0, 8'd0, 32'h0000_1000,
             64'h0, 8'h00, 64'h1716151413121110, 1'b0, 1'b0, "read");
  endtask

  task automatic test_timing_cfg();
    run_xfer(1'b0, 8'hA0, 8'd1, 2'd3, 2'd2, 8'd10, 32'h8000_0004,
             64'hDEADBEEF00C0FFEE, 8'h5A, 64'h0, 1'b0, 1'b0, "timing_wr");
    run_xfer(1'b1, 8'h20, 8'd255, 2'd3, 2'd2, 8'd255, 32'h7FFF_FFF8,
             64'h0, 8'h00, {$urandom, $urandom}, 1'b0, 1'b0, "timing_rd_max");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      run_xfer(1'($urandom), 8'($urandom), 8'($urandom_range(0, 12)), 2'($urandom),
               2'($urandom), 8'($urandom_range(0, 40)), $urandom, {$urandom, $urandom},
               8'($urandom), {$urandom, $urandom}, 1'b0, 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_xfer(1'b1, 8'h20, 8'd2, 2'd1, 2'd0, 8'd3, $urandom, 64'h0, 8'h00,
             {$urandom, $urandom}, 1'b1, 1'b0, "b2b_0");
    run_xfer(1'b0, 8'hA0, 8'd0, 2'd0, 2'd1, 8'd0, $urandom, {$urandom, $urandom},
             8'($urandom), 64'h0, 1'b1, 1'b1, "b2b_1");
    run_xfer(1'b1, 8'h20, 8'd3, 2'd2, 2'd3, 8'd1, $urandom, 64'h0, 8'h00,
             {$urandom, $urandom}, 1'b0, 1'b1, "b2b_2");
  endtask

  task automatic test_reset_mid();
    xfer_valid_i = 1'b1; xfer_rdwr_i = 1'b0; cfg_cmd_i = 8'hA0; cfg_lat_i = '0;
    cfg_tcsp_i = '0; cfg_tchd_i = '0; cfg_recy_i = '0; addr_i = $urandom;
    wr_data_i = {$urandom, $urandom}; wr_mask_i = 8'hFF;
    @(posedge clk_i);
    #1 xfer_valid_i = 1'b0;
    repeat (11) @(negedge clk_i);   // DATA byte 3 of an all-zero-cfg write
    n_checks++;
    if (psram_io_en_o !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid precondition io_en: got %b, required 1", psram_io_en_o);
    end
    #2 rst_n_i = 1'b0;
    #1;
    n_checks++;
    if ({psram_ce_o, psram_sck_o, psram_io_en_o} !== 3'b100) begin
      n_errors++;
      $display("FAIL rst_mid async pins: got ce/sck/en=%b, required 100",
               {psram_ce_o, psram_sck_o, psram_io_en_o});
    end
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    exp_rd  = '0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk_i);
      n_checks++;
      if (xfer_done_o !== 1'b0 || xfer_ready_o !== 1'b1 || psram_ce_o !== 1'b1) begin
        n_errors++;
        $display("FAIL rst_mid after c=%0d: got done=%b ready=%b ce=%b, required 0 1 1",
                 c, xfer_done_o, xfer_ready_o, psram_ce_o);
      end
    end
    n_checks++;
    if (rd_data_o !== exp_rd) begin
      n_errors++;
      $display("FAIL rst_mid rd_data: got %h, required %h", rd_data_o, exp_rd);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_masked_write();
    test_read();
    test_timing_cfg();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_read();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
